// File: rtl/cp0_pkg.sv
// CP0 shared definitions: register numbers, exception codes, field positions.
// Timer registers only exist when CP0_TIMER_EN is defined.
package cp0_pkg;

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_SR      = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] REG_PRID    = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int SR_IE     = 0;
  localparam int SR_EXL    = 1;
  localparam int SR_IM_LO  = 10;
  localparam int CA_EXC_LO = 2;
  localparam int CA_IP_LO  = 10;
  localparam int CA_BD     = 31;

  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer with sticky compare-match flag.
// Instantiated by cp0_exc_ctrl only under CP0_TIMER_EN.
module cp0_timer (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        we_count,
  input  logic        we_compare,
  input  logic [31:0] din,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        tip
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        tip_q, tip_d;

  always_comb begin
    count_d   = count_q + 32'd1;
    compare_d = compare_q;
    tip_d     = tip_q | (count_q == compare_q);
    if (we_count) count_d = din;
    if (we_compare) begin
      compare_d = din;
      tip_d     = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      count_q   <= '0;
      compare_q <= 32'hFFFF_FFFF;
      tip_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      tip_q     <= tip_d;
    end
  end

  assign count   = count_q;
  assign compare = compare_q;
  assign tip     = tip_q;

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller beside M: SR, Cause, EPC, PRId.
// Define CP0_TIMER_EN to add Count/Compare feeding HWInt[7].
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID_VAL = 32'h4255_4141
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [5:0]  HWInt,
  input  logic [4:0]  ExcCodeM,
  input  logic [31:0] PCM,
  input  logic        BDM,
  input  logic        WE,
  input  logic [4:0]  WAddr,
  input  logic [4:0]  RAddr,
  input  logic [31:0] DIn,
  input  logic        EretM,
  output logic [31:0] DOut,
  output logic        IntReq,
  output logic [31:0] EPCOut,
  output logic        EXLOut
);

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_q, exc_d;
  logic [31:0] epc_q, epc_d;

  logic [5:0]  hw;
  logic        int_pend;
  logic        exc_pend;
  logic        wr_ok;
  logic [31:0] sr_rd;
  logic [31:0] cause_rd;

`ifdef CP0_TIMER_EN
  logic [31:0] count;
  logic [31:0] compare;
  logic        tip;

  cp0_timer u_timer (
    .Clk        (Clk),
    .Reset      (Reset),
    .we_count   (wr_ok && WAddr == REG_COUNT),
    .we_compare (wr_ok && WAddr == REG_COMPARE),
    .din        (DIn),
    .count      (count),
    .compare    (compare),
    .tip        (tip)
  );

  assign hw = HWInt | {tip, 5'b0};
`else
  assign hw = HWInt;
`endif

  assign int_pend = (|(hw & im_q)) & ie_q & ~exl_q;
  assign exc_pend = (ExcCodeM != EXC_INT) & ~exl_q;
  assign IntReq   = int_pend | exc_pend;
  // The instruction in M is flushed on IntReq, so its mtc0 must not land.
  assign wr_ok    = WE & ~IntReq;

  always_comb begin
    im_d  = im_q;
    exl_d = exl_q;
    ie_d  = ie_q;
    bd_d  = bd_q;
    ip_d  = hw;
    exc_d = exc_q;
    epc_d = epc_q;
    if (IntReq) begin
      exl_d = 1'b1;
      exc_d = int_pend ? EXC_INT : ExcCodeM;
      bd_d  = BDM;
      epc_d = BDM ? PCM - 32'd4 : PCM;
    end else begin
      if (EretM) exl_d = 1'b0;
      if (WE) begin
        case (WAddr)
          REG_SR: begin
            im_d  = DIn[SR_IM_LO +: 6];
            exl_d = DIn[SR_EXL];
            ie_d  = DIn[SR_IE];
          end
          REG_EPC: epc_d = {DIn[31:2], 2'b00};
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      im_q  <= '0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      bd_q  <= 1'b0;
      ip_q  <= '0;
      exc_q <= '0;
      epc_q <= '0;
    end else begin
      im_q  <= im_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      bd_q  <= bd_d;
      ip_q  <= ip_d;
      exc_q <= exc_d;
      epc_q <= epc_d;
    end
  end

  assign sr_rd    = {16'b0, im_q, 8'b0, exl_q, ie_q};
  assign cause_rd = {bd_q, 15'b0, ip_q, 3'b0, exc_q, 2'b0};

  always_comb begin
    DOut = '0;
    unique case (1'b1)
      (RAddr == REG_SR):      DOut = sr_rd;
      (RAddr == REG_CAUSE):   DOut = cause_rd;
      (RAddr == REG_EPC):     DOut = epc_q;
      (RAddr == REG_PRID):    DOut = PRID_VAL;
`ifdef CP0_TIMER_EN
      (RAddr == REG_COUNT):   DOut = count;
      (RAddr == REG_COMPARE): DOut = compare;
`endif
      default:                DOut = '0;
    endcase
  end

  assign EPCOut = epc_q;
  assign EXLOut = exl_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed and random checks of cp0_exc_ctrl against a word-level model.
// Timer section runs only when CP0_TIMER_EN is defined.
module tb_cp0_exc_ctrl;

  localparam logic [31:0] PRID = 32'h4255_4141;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [5:0]  HWInt;
  logic [4:0]  ExcCodeM;
  logic [31:0] PCM;
  logic        BDM;
  logic        WE;
  logic [4:0]  WAddr;
  logic [4:0]  RAddr;
  logic [31:0] DIn;
  logic        EretM;
  logic [31:0] DOut;
  logic        IntReq;
  logic [31:0] EPCOut;
  logic        EXLOut;

  int errors = 0;
  int checks = 0;

  // reference state as architectural register words
  logic [31:0] sr_m, cause_m, epc_m;
  logic [31:0] cnt_m, cmp_m;
  logic        tip_m;

  cp0_exc_ctrl #(.PRID_VAL(PRID)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .HWInt    (HWInt),
    .ExcCodeM (ExcCodeM),
    .PCM      (PCM),
    .BDM      (BDM),
    .WE       (WE),
    .WAddr    (WAddr),
    .RAddr    (RAddr),
    .DIn      (DIn),
    .EretM    (EretM),
    .DOut     (DOut),
    .IntReq   (IntReq),
    .EPCOut   (EPCOut),
    .EXLOut   (EXLOut)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] m_hw();
    logic [5:0] h;
    h = HWInt;
`ifdef CP0_TIMER_EN
    if (tip_m) h[5] = 1'b1;
`endif
    return h;
  endfunction

  function automatic logic m_int();
    return ((m_hw() & sr_m[15:10]) != 0) && sr_m[0] && !sr_m[1];
  endfunction

  function automatic logic m_req();
    return m_int() || (ExcCodeM != 0 && !sr_m[1]);
  endfunction

  function automatic logic [31:0] m_dout(input logic [4:0] a);
    case (a)
      5'd12: return sr_m;
      5'd13: return cause_m;
      5'd14: return epc_m;
      5'd15: return PRID;
`ifdef CP0_TIMER_EN
      5'd9:  return cnt_m;
      5'd11: return cmp_m;
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_reset();
    sr_m = 0; cause_m = 0; epc_m = 0;
    cnt_m = 0; cmp_m = 32'hFFFF_FFFF; tip_m = 0;
  endtask

  task automatic settle();
    #1;
    chk("irq", {31'b0, IntReq}, {31'b0, m_req()});
    chk("exl", {31'b0, EXLOut}, {31'b0, sr_m[1]});
    chk("epc", EPCOut, epc_m);
    chk("dout", DOut, m_dout(RAddr));
  endtask

  task automatic tick();
    logic [31:0] n_sr, n_epc, n_cnt, n_cmp;
    logic [31:0] bd, code;
    logic        n_tip;
    n_sr  = sr_m;
    n_epc = epc_m;
    bd    = cause_m >> 31;
    code  = (cause_m >> 2) & 32'h1F;
    n_cnt = cnt_m + 1;
    n_cmp = cmp_m;
    n_tip = tip_m || (cnt_m == cmp_m);
    if (m_req()) begin
      n_sr  = n_sr | 32'h2;
      code  = m_int() ? 0 : 32'(ExcCodeM);
      bd    = 32'(BDM);
      n_epc = BDM ? PCM - 4 : PCM;
    end else begin
      if (EretM) n_sr = n_sr & ~32'h2;
      if (WE) begin
        if (WAddr == 12) n_sr = DIn & 32'h0000_FC03;
        if (WAddr == 14) n_epc = DIn & ~32'h3;
        if (WAddr == 9)  n_cnt = DIn;
        if (WAddr == 11) begin
          n_cmp = DIn;
          n_tip = 0;
        end
      end
    end
    cause_m = (bd << 31) | (32'(m_hw()) << 10) | (code << 2);
    @(posedge Clk);
    sr_m  = n_sr;
    epc_m = n_epc;
`ifdef CP0_TIMER_EN
    cnt_m = n_cnt;
    cmp_m = n_cmp;
    tip_m = n_tip;
`endif
    @(negedge Clk);
  endtask

  task automatic idle();
    HWInt = 0; ExcCodeM = 0; PCM = 0; BDM = 0;
    WE = 0; WAddr = 0; DIn = 0; EretM = 0;
  endtask

  task automatic do_reset();
    RAddr = 12;
    Reset = 1'b0;
    #1;
    chk("rst_irq", {31'b0, IntReq}, 32'h0);
    chk("rst_exl", {31'b0, EXLOut}, 32'h0);
    chk("rst_epc", EPCOut, 32'h0);
    chk("rst_sr", DOut, 32'h0);
    m_reset();
    Reset = 1'b1;
  endtask

  initial begin
    logic [4:0] regs [8];
    int r;
    bit seen;
    regs = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd20, 5'd0};
    idle();
    RAddr = 12;
    m_reset();
    Reset = 1'b0;
    #1;
    chk("init_irq", {31'b0, IntReq}, 32'h0);
    chk("init_exl", {31'b0, EXLOut}, 32'h0);
    chk("init_epc", EPCOut, 32'h0);
    @(negedge Clk);
    Reset = 1'b1;

    // AdEL from fetch reaches M
    ExcCodeM = 4; PCM = 32'h3002; RAddr = 13;
    settle();
    chk("adel_irq", {31'b0, IntReq}, 32'h1);
    tick();
    ExcCodeM = 10;
    settle();
    chk("adel_cause", DOut, 32'h0000_0010);
    chk("adel_epc", EPCOut, 32'h3002);
    chk("adel_exl", {31'b0, EXLOut}, 32'h1);
    chk("nested_drop", {31'b0, IntReq}, 32'h0);
    tick();
    idle();
    EretM = 1;
    tick();

    // interrupt on a delay-slot instruction
    idle();
    WE = 1; WAddr = 12; DIn = 32'h0000_0401;
    tick();
    idle();
    HWInt = 6'b000001; PCM = 32'h3020; BDM = 1;
    settle();
    chk("int_irq", {31'b0, IntReq}, 32'h1);
    tick();
    BDM = 0;
    settle();
    chk("int_cause", DOut, 32'h8000_0400);
    chk("int_epc", EPCOut, 32'h301C);

    // mtc0 lost under IntReq, eret, re-interrupt
    EretM = 1;
    settle();
    tick();
    EretM = 0; PCM = 32'h3040;
    WE = 1; WAddr = 12; DIn = 0;
    settle();
    chk("flush_irq", {31'b0, IntReq}, 32'h1);
    tick();
    WE = 0; RAddr = 12;
    settle();
    chk("flush_sr", DOut, 32'h0000_0403);
    EretM = 1;
    tick();
    EretM = 0;
    settle();
    chk("reint_irq", {31'b0, IntReq}, 32'h1);
    chk("reint_exl", {31'b0, EXLOut}, 32'h0);
    tick();

    // EPC write alignment and read decode
    idle();
    EretM = 1;
    tick();
    idle();
    WE = 1; WAddr = 14; DIn = 32'h0000_3007;
    tick();
    idle();
    settle();
    chk("epc_wr", EPCOut, 32'h3004);
    RAddr = 15;
    settle();
    chk("prid", DOut, PRID);
    RAddr = 20;
    settle();
    chk("unk_rd", DOut, 32'h0);

    // asynchronous reset mid-handler
    ExcCodeM = 4; PCM = 32'h3010;
    tick();
    idle();
    settle();
    chk("pre_rst_epc", EPCOut, 32'h3010);
    chk("pre_rst_exl", {31'b0, EXLOut}, 32'h1);
    do_reset();
    @(negedge Clk);

    for (int i = 0; i < 400; i++) begin
      HWInt = ($urandom_range(3) == 0) ? 6'($urandom) : 6'h0;
      r = $urandom_range(15);
      ExcCodeM = (r == 0) ? 5'd4 : (r == 1) ? 5'd10 :
                 (r == 2) ? 5'd12 : (r == 3) ? 5'd5 : 5'd0;
      PCM   = $urandom;
      BDM   = 1'($urandom);
      EretM = ($urandom_range(5) == 0);
      WE    = !EretM && ($urandom_range(2) == 0);
      WAddr = regs[$urandom_range(7)];
      RAddr = regs[$urandom_range(7)];
      DIn   = $urandom;
      settle();
      tick();
    end

`ifdef CP0_TIMER_EN
    idle();
    do_reset();
    @(negedge Clk);
    m_reset();
    WE = 1; WAddr = 9; DIn = 0;
    tick();
    WAddr = 11; DIn = 5;
    tick();
    WAddr = 12; DIn = 32'h8001;
    tick();
    idle();
    RAddr = 9;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      settle();
      if (IntReq) seen = 1;
      else tick();
    end
    chk("tmr_seen", {31'b0, seen}, 32'h1);
    chk("tmr_cnt", DOut, 32'd6);
    tick();
    WE = 1; WAddr = 11; DIn = 100;
    tick();
    idle();
    EretM = 1;
    tick();
    idle();
    settle();
    chk("tip_clr", {31'b0, IntReq}, 32'h0);
    WE = 1; WAddr = 9; DIn = 32'hFFFF_FFFE;
    tick();
    idle();
    RAddr = 9;
    settle();
    chk("cnt_fe", DOut, 32'hFFFF_FFFE);
    tick();
    settle();
    chk("cnt_ff", DOut, 32'hFFFF_FFFF);
    tick();
    settle();
    chk("cnt_wrap", DOut, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
- Coprocessor-0 exception/interrupt controller; the producer side of the fetch stage's IntReq/eret/EPC redirect interface.
- Collects per-stage exception codes (fetch AdEL=4 travels down the pipe and arrives here at M), external hardware interrupts and mtc0/mfc0 accesses.
- Decides when to redirect the PC to the handler at 0x0000_4180, latches the victim PC into EPC, and supplies EPC for eret.
- Sits beside the M stage.

Parameters:
- PRID_VAL, 32'h4255_4141, read-only processor ID value returned for register 15.
- HANDLER_PC, 32'h0000_4180, handler address; informational only, since fetch applies the constant itself.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- HWInt  in  6  external interrupt lines [7:2], level-sensitive.
- ExcCodeM  in  5  exception code of the instruction in M; 0 means none.
- PCM  in  32  PC of the instruction in M.
- BDM  in  1  instruction in M is in a branch delay slot.
- WE  in  1  mtc0 write enable, from M.
- WAddr  in  5  mtc0 destination register number.
- RAddr  in  5  mfc0 source register number.
- DIn  in  32  mtc0 write data.
- EretM  in  1  eret in M.
- DOut  out  32  mfc0 read data, combinational on RAddr.
- IntReq  out  1  take exception/interrupt this cycle; drives the flush and the fetch redirect.
- EPCOut  out  32  current EPC, combinational, to fetch.
- EXLOut  out  1  current SR.EXL.

Behaviour:
- Registers:
  - SR (12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause (13): BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0.
  - EPC (14): 32 bits.
  - PRId (15): constant PRID_VAL.
  - Any other RAddr reads 0.
- Reset (Reset=0, asynchronous): SR=0, Cause=0, EPC=0, so IntReq=0 and EXLOut=0 immediately.
- Combinational request logic:
  - IntPend = |(HWInt & SR.IM) & SR.IE & ~SR.EXL.
  - ExcPend = (ExcCodeM != 0) & ~SR.EXL.
  - IntReq = IntPend | ExcPend; zero-latency, same cycle.
- Cause.IP is loaded from HWInt every clock edge, independent of everything else.
- Rising edge, evaluated in this priority order:
  1. IntReq=1:
     - SR.EXL <= 1.
     - Cause.ExcCode <= IntPend ? 0 : ExcCodeM; interrupt beats synchronous exception.
     - Cause.BD <= BDM.
     - EPC <= BDM ? PCM-4 : PCM, taken as a full 32-bit value; a misaligned PCM is stored as-is.
     - A concurrent WE is discarded, because the instruction in M is being flushed.
  2. Else EretM=1: SR.EXL <= 0. A concurrent WE still applies, since eret and mtc0 cannot coexist in M.
  3. Else WE=1 writes the register selected by WAddr:
     - SR: only IM, EXL, IE are written.
     - Cause: only IP-independent bits are writable, and those are none; writes are ignored.
     - EPC: stored as {DIn[31:2],2'b00}.
     - PRId and unknown numbers: ignored.
- Read-after-write: DOut shows the old value in the write cycle; bypass is the forwarding unit's job.
- Nested events:
  - EXL=1 masks both interrupts and exceptions. An exception raised inside the handler is silently dropped, and ExcCodeM is ignored.
  - eret and IntReq cannot assert together, because eret is only meaningful with EXL=1, which forces IntReq=0.
  - IntPend may assert in the cycle after eret clears EXL.

Optional Feature:
- Macro CP0_TIMER_EN.
- When defined, adds Count (9) and Compare (11):
  - Count increments by 1 every cycle and wraps 0xFFFF_FFFF->0.
  - An mtc0 write to Count loads DIn; that cycle does not increment.
  - An mtc0 write to Compare loads DIn and clears the timer-pending flag TIP.
  - TIP sets on the edge where Count equals Compare, is sticky, and is ORed into HWInt[7] for both IP and IntPend.
  - Reset: Count=0, Compare=0xFFFF_FFFF, TIP=0.
- When undefined: registers 9 and 11 read 0, writes to them are ignored, and HWInt passes through unchanged.

Decomposition:
- Shared package cp0_pkg holds:
  - register numbers: SR=12, CAUSE=13, EPC=14, PRID=15, COUNT=9, COMPARE=11;
  - ExcCode constants: INT=0, ADEL=4, ADES=5, RI=10, OV=12;
  - SR/Cause bit positions;
  - HANDLER_PC.
- One natural sub-module, cp0_timer (Count/Compare/TIP), instantiated only under CP0_TIMER_EN.

Test Plan:
- Reset held low mid-run after EXL=1, EPC=0x3010 -> IntReq=0, EXLOut=0, EPCOut=0, DOut(12)=0 immediately, without waiting for a clock.
- ExcCodeM=4, PCM=0x3002, BDM=0 -> IntReq=1 same cycle; after edge Cause(13)=0x0000_0010, EPC=0x3002, EXLOut=1; a second ExcCodeM=10 is then ignored (IntReq=0).
- mtc0 SR=0x0000_0401 (IM[10] set, IE=1), HWInt=6'b000001, PCM=0x3020, BDM=1 -> IntReq=1; Cause.BD=1, ExcCode=0, EPC=0x301C.
- IntReq and WE to SR in the same cycle with DIn=0 -> SR keeps 0x0401|EXL; EretM=1 next -> EXL clears; IntReq re-asserts the following cycle while HWInt is held.
- mtc0 EPC with DIn=0x0000_3007 -> EPCOut=0x3004; mfc0 15 -> PRID_VAL; mfc0 20 -> 0.
- CP0_TIMER_EN defined: Compare=5, SR=0x8001 -> IntReq rises in the cycle after Count==5; writing Compare clears TIP; Count wraps from 0xFFFF_FFFF to 0.
